// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-atomic round-robin AXI-Stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_rr_arbiter_pkg;

  // Arbiter FSM: IDLE picks the next input, BUSY streams one packet from it.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of an input index; at least one bit even for tiny N.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Rotating-priority picker: first set req bit searching last+1, last+2, ... modulo N.
// Latency: combinational.
// Backpressure: none; pure function of req and last.
//
// Ports:
//   req  - candidate mask (valid & enabled)
//   last - index granted most recently; it gets lowest priority
//   any  - at least one candidate present
//   idx  - winning index (0 when any=0)
module axis_rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = src_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          any,
  output logic [SW-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest requester is the
  // final assignment and therefore the winner.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = SW'(j);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin merge of N AXI-Stream inputs; winner index on out_TDEST.
// Latency: 1 cycle input beat -> out_TVALID; 1 arbitration cycle between packets.
// Backpressure: granted input ready = ~out_TVALID | out_TREADY; others held at 0.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_enable                     - per-input arbitration enable
//   in_TDATA/TVALID/TREADY/TLAST  - N packed input streams
//   out_TDATA/TVALID/TREADY/TLAST - registered merged stream
//   out_TDEST                     - source index of the current output beat
//   busy                          - a packet grant is held
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter  int N_INPUTS   = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SRC_WIDTH  = src_width(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            in_enable,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_TDATA,
  input  logic [N_INPUTS-1:0]            in_TVALID,
  output logic [N_INPUTS-1:0]            in_TREADY,
  input  logic [N_INPUTS-1:0]            in_TLAST,
  output logic [DATA_WIDTH-1:0]          out_TDATA,
  output logic                           out_TVALID,
  input  logic                           out_TREADY,
  output logic                           out_TLAST,
  output logic [SRC_WIDTH-1:0]           out_TDEST,
  output logic                           busy
);

  arb_state_t             state, state_nxt;
  logic [SRC_WIDTH-1:0]   grant, last_grant;
  logic                   pick_any;
  logic [SRC_WIDTH-1:0]   pick_idx;
  logic                   slot_free;
  logic                   accept;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;

  axis_rr_pick #(
    .N  (N_INPUTS),
    .SW (SRC_WIDTH)
  ) u_pick (
    .req  (in_TVALID & in_enable),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign slot_free = ~out_TVALID | out_TREADY;
  assign sel_data  = in_TDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last  = in_TLAST[grant];

  always_comb begin
    state_nxt = state;
    in_TREADY = '0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = BUSY;
      end
      BUSY: begin
        busy             = 1'b1;
        // Ready is masked during reset so no producer sees a handshake
        // that the reset is about to throw away.
        in_TREADY[grant] = slot_free & ~rst;
        accept           = in_TVALID[grant] & slot_free & ~rst;
        if (accept && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_WIDTH'(N_INPUTS - 1);
      out_TDATA  <= '0;
      out_TVALID <= 1'b0;
      out_TLAST  <= 1'b0;
      out_TDEST  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) grant <= pick_idx;
      if (accept && sel_last) last_grant <= grant;
      if (accept) begin
        out_TDATA  <= sel_data;
        out_TLAST  <= sel_last;
        out_TDEST  <= grant;
        out_TVALID <= 1'b1;
      end else if (out_TREADY) begin
        out_TVALID <= 1'b0;
      end
    end
  end

endmodule
